// File: rtl/chan_emu_pkg.sv
// Shared definitions for the IQ loopback channel emulator: rotation codes,
// noise LFSR constants, fill FSM states and the saturation helper.
package chan_emu_pkg;

    localparam logic [1:0] ROT_I_Q   = 2'd0;
    localparam logic [1:0] ROT_Q_NI  = 2'd1;
    localparam logic [1:0] ROT_NI_NQ = 2'd2;
    localparam logic [1:0] ROT_NQ_I  = 2'd3;

    localparam int unsigned     LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

    typedef enum logic {FILL, RUN} fill_state_e;

    // Clip a wide signed value into the range of a w-bit two's complement word.
    function automatic logic signed [31:0] sat_dw(input logic signed [31:0] x,
                                                  input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/chan_emu_lfsr16.sv
// 16-bit Galois LFSR noise source; advances only when step_i is high.
module lfsr16 import chan_emu_pkg::*; #(
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
    parameter int unsigned       OUT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             step_i,
    output logic [OUT_W-1:0] value_o
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (step_i) begin
            state_d = {1'b0, state_q[LFSR_W-1:1]} ^ (state_q[0] ? LFSR_POLY : '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= SEED;
        else         state_q <= state_d;
    end

    assign value_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/chan_emu.sv
// IQ loopback channel emulator: rotate -> gain -> noise/DC sum, then an
// optional sample-count delay line guarded by a fill FSM.
module chan_emu import chan_emu_pkg::*; #(
    parameter int unsigned DW      = 12,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned NOISE_W = 6,
    parameter logic [15:0] SEED_I  = 16'hACE1,
    parameter logic [15:0] SEED_Q  = 16'h1D2B
) (
    input  logic                       clk_32M768,
    input  logic                       rst_n_32M768,
    input  logic                       in_valid,
    input  logic signed [DW-1:0]       in_I,
    input  logic signed [DW-1:0]       in_Q,
    input  logic [1:0]                 ROT_CTRL,
    input  logic [2:0]                 GAIN_NUM,
    input  logic                       NOISE_EN,
    input  logic signed [DW-1:0]       DC_OFFSET,
    input  logic [$clog2(DEPTH)-1:0]   DELAY_CFG,
    input  logic                       SAT_CLR,
    output logic signed [DW-1:0]       out_I,
    output logic signed [DW-1:0]       out_Q,
    output logic                       out_valid,
    output logic                       sat_flag
);

    localparam int unsigned AW = $clog2(DEPTH);

    function automatic logic signed [31:0] ext(input logic signed [DW-1:0] x);
        return 32'(x);
    endfunction

    logic signed [DW-1:0] s1_i_q, s1_q_q, s1_i_d, s1_q_d;
    logic signed [DW-1:0] s2_i_q, s2_q_q, s2_i_d, s2_q_d;
    logic signed [DW-1:0] s3_i, s3_q;
    logic                 s1_v_q, s2_v_q;
    logic signed [DW-1:0] out_i_q, out_q_q, out_i_d, out_q_d;
    logic                 out_v_q, out_v_d;
    logic                 sat_q, sat_d, sat1, sat2, sat3;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_idx, cfg_q, fill_cnt_q, fill_cnt_d, cnt_inc;
    fill_state_e          state_q, state_d;
    logic                 cfg_chg;
    logic [NOISE_W-1:0]   nz_i, nz_q;
    logic signed [DW-1:0] mem_i_q [DEPTH];
    logic signed [DW-1:0] mem_q_q [DEPTH];

    logic signed [31:0] rot_i, rot_q, c1_i, c1_q;
    logic signed [31:0] gain_s, sh_i, sh_q, c2_i, c2_q;
    logic signed [31:0] noise_i, noise_q, sum_i, sum_q, c3_i, c3_q;

    lfsr16 #(.SEED(SEED_I), .OUT_W(NOISE_W)) u_lfsr_i (
        .clk_i(clk_32M768), .rst_ni(rst_n_32M768), .step_i(s2_v_q), .value_o(nz_i)
    );
    lfsr16 #(.SEED(SEED_Q), .OUT_W(NOISE_W)) u_lfsr_q (
        .clk_i(clk_32M768), .rst_ni(rst_n_32M768), .step_i(s2_v_q), .value_o(nz_q)
    );

    always_comb begin
        rot_i = ext(in_I);
        rot_q = ext(in_Q);
        case (ROT_CTRL)
            ROT_Q_NI:  begin rot_i = ext(in_Q);  rot_q = -ext(in_I); end
            ROT_NI_NQ: begin rot_i = -ext(in_I); rot_q = -ext(in_Q); end
            ROT_NQ_I:  begin rot_i = -ext(in_Q); rot_q = ext(in_I);  end
            default:   ;
        endcase
        c1_i   = sat_dw(rot_i, DW);
        c1_q   = sat_dw(rot_q, DW);
        s1_i_d = DW'(c1_i);
        s1_q_d = DW'(c1_q);
        sat1   = in_valid & ((c1_i != rot_i) | (c1_q != rot_q));

        gain_s = $signed({29'd0, GAIN_NUM});
        sh_i   = (ext(s1_i_q) * gain_s) >>> 2;
        sh_q   = (ext(s1_q_q) * gain_s) >>> 2;
        c2_i   = sat_dw(sh_i, DW);
        c2_q   = sat_dw(sh_q, DW);
        s2_i_d = DW'(c2_i);
        s2_q_d = DW'(c2_q);
        sat2   = s1_v_q & ((c2_i != sh_i) | (c2_q != sh_q));

        noise_i = '0;
        noise_q = '0;
        if (NOISE_EN) begin
            noise_i[NOISE_W-1:0] = nz_i;
            noise_q[NOISE_W-1:0] = nz_q;
        end
        sum_i = ext(s2_i_q) + noise_i + ext(DC_OFFSET);
        sum_q = ext(s2_q_q) + noise_q + ext(DC_OFFSET);
        c3_i  = sat_dw(sum_i, DW);
        c3_q  = sat_dw(sum_q, DW);
        s3_i  = s2_v_q ? DW'(c3_i) : '0;
        s3_q  = s2_v_q ? DW'(c3_q) : '0;
        sat3  = s2_v_q & ((c3_i != sum_i) | (c3_q != sum_q));

        sat_d = (sat1 | sat2 | sat3) ? 1'b1 : (SAT_CLR ? 1'b0 : sat_q);
    end

    // A config change drops back to FILL; a write on that same edge is not
    // counted, so the first emitted sample is always written after the change.
    always_comb begin
        cfg_chg    = (DELAY_CFG != cfg_q);
        rd_idx     = wr_ptr_q - DELAY_CFG;
        cnt_inc    = fill_cnt_q + AW'(1);
        wr_ptr_d   = s2_v_q ? wr_ptr_q + AW'(1) : wr_ptr_q;
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        out_v_d    = 1'b0;
        out_i_d    = '0;
        out_q_d    = '0;
        if (cfg_chg) begin
            state_d    = FILL;
            fill_cnt_d = '0;
        end else if (state_q == FILL && s2_v_q && DELAY_CFG != '0) begin
            fill_cnt_d = cnt_inc;
            if (cnt_inc == DELAY_CFG) state_d = RUN;
        end
        if (DELAY_CFG == '0) begin
            out_v_d = s2_v_q;
            out_i_d = s3_i;
            out_q_d = s3_q;
        end else if (state_q == RUN && !cfg_chg && s2_v_q) begin
            out_v_d = 1'b1;
            out_i_d = mem_i_q[rd_idx];
            out_q_d = mem_q_q[rd_idx];
        end
    end

    always_ff @(posedge clk_32M768) begin
        if (s2_v_q) begin
            mem_i_q[wr_ptr_q] <= s3_i;
            mem_q_q[wr_ptr_q] <= s3_q;
        end
    end

    always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
        if (!rst_n_32M768) begin
            s1_i_q     <= '0;
            s1_q_q     <= '0;
            s1_v_q     <= 1'b0;
            s2_i_q     <= '0;
            s2_q_q     <= '0;
            s2_v_q     <= 1'b0;
            out_i_q    <= '0;
            out_q_q    <= '0;
            out_v_q    <= 1'b0;
            sat_q      <= 1'b0;
            wr_ptr_q   <= '0;
            cfg_q      <= '0;
            fill_cnt_q <= '0;
            state_q    <= FILL;
        end else begin
            s1_i_q     <= s1_i_d;
            s1_q_q     <= s1_q_d;
            s1_v_q     <= in_valid;
            s2_i_q     <= s2_i_d;
            s2_q_q     <= s2_q_d;
            s2_v_q     <= s1_v_q;
            out_i_q    <= out_i_d;
            out_q_q    <= out_q_d;
            out_v_q    <= out_v_d;
            sat_q      <= sat_d;
            wr_ptr_q   <= wr_ptr_d;
            cfg_q      <= DELAY_CFG;
            fill_cnt_q <= fill_cnt_d;
            state_q    <= state_d;
        end
    end

    assign out_I     = out_i_q;
    assign out_Q     = out_q_q;
    assign out_valid = out_v_q;
    assign sat_flag  = sat_q;

endmodule
